aes_byte_disp_ctrl: RTL and testbench
=====================================

AES_BYTE_DISP_CTRL -- requirements
Module: aes_byte_disp_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 50_000_000, SHALL set the clock cycles each byte is displayed; legal range 2..2^32-1.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 blk_in  input  128  SHALL carry the AES block; byte k = blk_in[8k+7:8k].
REQ-005 blk_valid  input  1  SHALL mark blk_in as valid.
REQ-006 blk_ready  output  1  SHALL indicate the controller accepts a block this cycle.
REQ-007 step  input  1  SHALL be a single-cycle (pre-debounced) manual advance request.
REQ-008 hold  input  1  SHALL freeze automatic advance while high.
REQ-009 byte_out  output  8  SHALL be the currently selected byte, fed to the byte-to-7-segment decoder.
REQ-010 byte_idx  output  4  SHALL be the index (0..15) of byte_out.
REQ-011 show_en  output  1  SHALL be high while byte_out is meaningful; the display blanks when low.
REQ-012 done  output  1  SHALL pulse high for one cycle when the last byte's dwell ends.

Function
REQ-013 The FSM SHALL have states IDLE, SHOW and DONE.
REQ-014 A block SHALL be accepted on a cycle with blk_valid && blk_ready; the next cycle all 128 bits are registered, byte_idx=0, dwell count=0, state=SHOW.
REQ-015 blk_ready SHALL be 1 in IDLE, DONE and SHOW; a block accepted in SHOW restarts display at index 0.
REQ-016 show_en SHALL be 0 in IDLE and 1 in SHOW and DONE; byte_out SHALL be a registered mux of the stored block by byte_idx, with no added latency beyond byte_idx.
REQ-017 In SHOW with hold=0, the dwell counter SHALL increment each cycle; at DWELL_CYCLES-1 it SHALL clear and byte_idx SHALL advance.
REQ-018 step=1 in SHOW SHALL advance byte_idx and clear the dwell counter next cycle, regardless of hold.
REQ-019 Simultaneous step and dwell expiry SHALL advance byte_idx exactly once.
REQ-020 hold=1 SHALL freeze the dwell counter at its current value; release resumes from that value.
REQ-021 Advancing from byte_idx 15 SHALL assert done for one cycle; the subsequent behaviour is set by REQ-025/REQ-026.
REQ-022 Simultaneous block acceptance and advance SHALL give priority to acceptance (byte_idx=0).
REQ-023 In IDLE and DONE, step and hold SHALL have no effect.

Reset
REQ-024 rst=1 SHALL on the next edge force state=IDLE, byte_idx=0, byte_out=0x00, show_en=0, done=0, dwell count=0 and stored block=0; mid-display reset discards the block.

Configuration
REQ-025 With DISPLAY_LOOP_EN defined, advancing from index 15 SHALL wrap byte_idx to 0 and remain in SHOW; DONE is unreachable.
REQ-026 Without DISPLAY_LOOP_EN, advancing from index 15 SHALL enter DONE with byte_idx held at 15 and byte_out unchanged, until a new block or reset.

Structure
REQ-027 Package aes_disp_pkg SHALL hold NUM_BYTES=16, IDX_W=4 and the state type/encodings.
REQ-028 The dwell counter SHALL be a sub-module dwell_timer (inputs clr, en; output expire) instantiated once.

Verification (DWELL_CYCLES=4)
REQ-029 blk_in=0x0F0E...0100, valid 1 cycle -> byte_out 0x00,0x01,... each for 4 cycles; show_en=1.
REQ-030 Loop off: after index 15 dwell -> done pulse 1 cycle, state DONE, byte_out=0x0F held; loop on: byte_idx wraps to 0, no DONE.
REQ-031 hold=1 for 10 cycles at dwell count 2 -> byte_idx unchanged; after release, advance 2 cycles later.
REQ-032 step coinciding with dwell expiry at index 3 -> byte_idx=4 (not 5); step while hold=1 -> advances.
REQ-033 New block accepted at index 9 -> next cycle byte_idx=0, byte_out = new byte 0.
REQ-034 rst=1 at index 7 -> next cycle all outputs 0, blk_ready=1, state IDLE.

Source files
------------

// File: rtl/aes_disp_pkg.sv
// Shared sizes and FSM encoding for the AES byte display controller.
package aes_disp_pkg;

  localparam int NUM_BYTES = 16;
  localparam int IDX_W     = 4;
  localparam int BYTE_W    = 8;
  localparam int BLK_W     = NUM_BYTES * BYTE_W;
  localparam int DWELL_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/aes_byte_disp_ctrl_dwell_timer.sv
// Dwell counter: counts enabled cycles and flags the last one of each dwell period.
import aes_disp_pkg::*;

module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [DWELL_W-1:0] LAST_CNT = DWELL_W'(DWELL_CYCLES - 1);

  logic [DWELL_W-1:0] cnt_reg;
  logic [DWELL_W-1:0] cnt_next;

  // Expiry only counts while enabled, so a held count never fires.
  assign expire = en && (cnt_reg == LAST_CNT);

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = expire ? '0 : cnt_reg + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/aes_byte_disp_ctrl.sv
// Steps through the 16 bytes of an AES block for a 7-segment display.
// Define DISPLAY_LOOP_EN to wrap from byte 15 back to byte 0 instead of stopping in DONE.
import aes_disp_pkg::*;

module aes_byte_disp_ctrl #(
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BLK_W-1:0]  blk_in,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic              step,
  input  logic              hold,
  output logic [BYTE_W-1:0] byte_out,
  output logic [IDX_W-1:0]  byte_idx,
  output logic              show_en,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [BLK_W-1:0]    blk_reg, blk_next;
  logic [BYTE_W-1:0]   byte_reg, byte_next;
  logic                done_reg, done_next;
  logic [BYTE_W-1:0]   blk_bytes [NUM_BYTES];

  logic in_show;
  logic accept;
  logic expire;
  logic advance;

  // The controller can always take a new block, including mid-display.
  assign blk_ready = 1'b1;
  assign accept    = blk_valid && blk_ready;
  assign in_show   = (state_reg == ST_SHOW);
  assign advance   = in_show && (step || expire);

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept || !in_show || step),
    .en    (in_show && !hold),
    .expire(expire)
  );

  // Byte mux works on the next-state block/index so byte_out lines up with byte_idx.
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
      assign blk_bytes[gi] = blk_next[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    blk_next   = blk_reg;
    done_next  = 1'b0;
    if (accept) begin
      state_next = ST_SHOW;
      idx_next   = '0;
      blk_next   = blk_in;
    end else if (advance) begin
      if (idx_reg == LAST_IDX) begin
        done_next = 1'b1;
`ifdef DISPLAY_LOOP_EN
        idx_next  = '0;
`else
        state_next = ST_DONE;
`endif
      end else begin
        idx_next = idx_reg + IDX_W'(1);
      end
    end
    byte_next = blk_bytes[idx_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      blk_reg   <= '0;
      byte_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      blk_reg   <= blk_next;
      byte_reg  <= byte_next;
      done_reg  <= done_next;
    end
  end

  assign byte_out = byte_reg;
  assign byte_idx = idx_reg;
  assign show_en  = (state_reg != ST_IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_aes_byte_disp_ctrl.sv
// Scoreboard bench for aes_byte_disp_ctrl with a 4-cycle dwell; build with or without DISPLAY_LOOP_EN.
`timescale 1ns/1ps

module tb_aes_byte_disp_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] blk_in;
  logic         blk_valid;
  logic         blk_ready;
  logic         step;
  logic         hold;
  logic [7:0]   byte_out;
  logic [3:0]   byte_idx;
  logic         show_en;
  logic         done;

  always #5 clk = ~clk;

  aes_byte_disp_ctrl #(
    .DWELL_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .blk_in   (blk_in),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .step     (step),
    .hold     (hold),
    .byte_out (byte_out),
    .byte_idx (byte_idx),
    .show_en  (show_en),
    .done     (done)
  );

  typedef struct {
    logic [3:0] idx;
    logic [7:0] bval;
    logic       show;
    logic       dn;
    int         gap;   // expected cycles since previous event, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   compared   = 0;
  int   mismatched = 0;
  int   neg_cnt    = 0;
  int   last_neg   = 0;
  bit   mon_en     = 1'b0;
  bit   have_prev  = 1'b0;
  bit   final_check = 1'b0;
  bit   final_done  = 1'b0;
  logic [3:0] prev_idx;
  logic [7:0] prev_byte;
  logic       prev_show;

  logic [127:0] blk_a = 128'h0F0E0D0C0B0A09080706050403020100;
  logic [127:0] blk_b = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  logic [127:0] blk_c = 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0;

  function automatic logic [7:0] byte_of(input logic [127:0] blk, input int k);
    return blk[8*k +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] i, input logic [7:0] b, input logic s,
                      input logic d, input int g);
    exp_t x;
    x.idx = i; x.bval = b; x.show = s; x.dn = d; x.gap = g;
    exp_q.push_back(x);
  endtask

  // Monitor: an event is any change of index/byte/show_en, or a done pulse.
  always @(negedge clk) begin
    neg_cnt++;
    if (mon_en) begin
      if (!have_prev || byte_idx != prev_idx || byte_out != prev_byte ||
          show_en != prev_show || done) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: got idx=%0d byte=%02h show=%0b done=%0b, required no event",
                   byte_idx, byte_out, show_en, done);
        end else begin
          e = exp_q.pop_front();
          compared++;
          if (byte_idx !== e.idx || byte_out !== e.bval || show_en !== e.show ||
              done !== e.dn || blk_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL event: got idx=%0d byte=%02h show=%0b done=%0b ready=%0b, required idx=%0d byte=%02h show=%0b done=%0b ready=1",
                     byte_idx, byte_out, show_en, done, blk_ready, e.idx, e.bval, e.show, e.dn);
          end else begin
            $display("event idx=%0d byte=%02h show=%0b done=%0b at cycle %0d",
                     byte_idx, byte_out, show_en, done, neg_cnt);
          end
          if (e.gap != 0) begin
            compared++;
            if (neg_cnt - last_neg != e.gap) begin
              mismatched++;
              $display("FAIL event_gap idx=%0d: got %0d cycles, required %0d",
                       e.idx, neg_cnt - last_neg, e.gap);
            end
          end
        end
        last_neg = neg_cnt;
      end
      prev_idx  = byte_idx;
      prev_byte = byte_out;
      prev_show = show_en;
      have_prev = 1'b1;
    end
    if (final_check && !final_done) begin
      final_done = 1'b1;
      compared++;
      if (exp_q.size() != 0) begin
        mismatched++;
        $display("FAIL pending_events: got %0d left in queue, required 0", exp_q.size());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; blk_in = '0; blk_valid = 1'b0; step = 1'b0; hold = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    push(4'd0, 8'h00, 1'b0, 1'b0, 0);
    mon_en = 1'b1;
    repeat (2) tick();

    // Block A: each byte shown for 4 cycles, then the end-of-block pulse.
    blk_in = blk_a; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int k = 0; k < 16; k++)
      push(4'(k), byte_of(blk_a, k), 1'b1, 1'b0, (k == 0) ? 0 : 4);
`ifdef DISPLAY_LOOP_EN
    push(4'd0, 8'h00, 1'b1, 1'b1, 4);
    repeat (64) tick();
`else
    push(4'd15, 8'h0F, 1'b1, 1'b1, 4);
    repeat (64) tick();
    // DONE ignores step and hold.
    step = 1'b1; tick(); step = 1'b0;
    hold = 1'b1; repeat (3) tick(); hold = 1'b0;
    tick();
`endif

    // Block B: hold at dwell count 2, then step/expiry collision, then step under hold.
    blk_in = blk_b; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    push(4'd0, byte_of(blk_b, 0), 1'b1, 1'b0, 0);
    tick(); tick();
    hold = 1'b1;
    repeat (10) tick();
    hold = 1'b0;
    push(4'd1, byte_of(blk_b, 1), 1'b1, 1'b0, 14);
    tick(); tick();
    push(4'd2, byte_of(blk_b, 2), 1'b1, 1'b0, 4);
    push(4'd3, byte_of(blk_b, 3), 1'b1, 1'b0, 4);
    repeat (11) tick();
    step = 1'b1;
    push(4'd4, byte_of(blk_b, 4), 1'b1, 1'b0, 4);
    tick();
    step = 1'b0;
    tick();
    hold = 1'b1;
    tick();
    step = 1'b1;
    push(4'd5, byte_of(blk_b, 5), 1'b1, 1'b0, 3);
    tick();
    step = 1'b0;
    repeat (6) tick();
    hold = 1'b0;
    push(4'd6, byte_of(blk_b, 6), 1'b1, 1'b0, 10);
    push(4'd7, byte_of(blk_b, 7), 1'b1, 1'b0, 4);
    push(4'd8, byte_of(blk_b, 8), 1'b1, 1'b0, 4);
    push(4'd9, byte_of(blk_b, 9), 1'b1, 1'b0, 4);
    repeat (16) tick();

    // New block at index 9, then a block arriving on the same cycle as an expiry.
    blk_in = blk_c; blk_valid = 1'b1;
    push(4'd0, byte_of(blk_c, 0), 1'b1, 1'b0, 1);
    tick();
    blk_valid = 1'b0;
    repeat (3) tick();
    blk_in = blk_a; blk_valid = 1'b1;
    push(4'd0, byte_of(blk_a, 0), 1'b1, 1'b0, 4);
    tick();
    blk_valid = 1'b0;
    for (int k = 1; k < 8; k++)
      push(4'(k), byte_of(blk_a, k), 1'b1, 1'b0, 4);
    repeat (28) tick();

    // Reset at index 7 blanks everything; IDLE ignores step and hold.
    rst = 1'b1;
    push(4'd0, 8'h00, 1'b0, 1'b0, 1);
    tick();
    rst = 1'b0;
    step = 1'b1; hold = 1'b1;
    tick();
    step = 1'b0;
    tick();
    hold = 1'b0;
    repeat (4) tick();

    final_check = 1'b1;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
